// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg: shared state encoding, mode bit positions and reset values for the SPI transfer scheduler
package spi_sched_pkg;
    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_START, S_BUSY, S_GAP} state_t;
    localparam int MODE_TX = 0;
    localparam int MODE_RX = 1;
    localparam int MODE_LB = 2;
    localparam logic [1:0] FREQ_RESET = 2'b01;
    // loopback only makes sense with both directions active
    function automatic logic mode_bad(input logic [2:0] m);
        return !(m[MODE_TX] || m[MODE_RX]) || (m[MODE_LB] && !(m[MODE_TX] && m[MODE_RX]));
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, one-hot grant, pointer advances on accept
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    logic last;
    always_comb grant = (&req) ? (last ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk) begin
        if (!reset) last <= 1'b1;
        else if (accept && |grant) last <= grant[1];
    end
endmodule

// File: rtl/spi_xfer_sched.sv
// spi_xfer_sched: arbitrates two requesters onto the SPI clock-control engine and sequences setup, start, completion/timeout and idle gap
module spi_xfer_sched
    import spi_sched_pkg::*;
#(
    parameter int SETUP_CYCLES   = 4,
    parameter int GAP_CYCLES     = 20,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_valid,
    input  logic [5:0] req_mode,
    input  logic [3:0] req_freq,
    output logic [1:0] req_ready,
    output logic [1:0] done_valid,
    output logic       done_err,
    output logic       busy,
    output logic       slave_tx_start,
    output logic       slave_rx_start,
    output logic       loopback,
    output logic [1:0] freq_control,
    input  logic       tx_done,
    input  logic       rx_valid
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ?
        ((TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES) :
        ((GAP_CYCLES > SETUP_CYCLES) ? GAP_CYCLES : SETUP_CYCLES);
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    state_t state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [1:0] grant;
    logic [2:0] m;
    logic gid, accept, fin, err;
    logic ftx, frx, ftx_n, frx_n, tx_q, rx_q;

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (req_valid),
        .accept(accept),
        .grant (grant)
    );

    assign cnt_inc = (cnt == CNT_W'(CNT_MAX)) ? cnt : cnt + 1'b1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt_inc;
        accept  = 1'b0;
        fin     = 1'b0;
        err     = 1'b0;
        ftx_n   = ftx;
        frx_n   = frx;
        unique case (state)
            S_IDLE: if (|req_valid) begin
                accept  = 1'b1;
                state_n = S_SETUP;
                cnt_n   = '0;
            end
            S_SETUP: if (mode_bad(m)) begin
                fin     = 1'b1;
                err     = 1'b1;
                state_n = S_GAP;
                cnt_n   = '0;
            end else if (cnt == CNT_W'(SETUP_CYCLES)) begin
                state_n = S_START;
                cnt_n   = '0;
            end
            S_START: begin
                ftx_n   = 1'b0;
                frx_n   = 1'b0;
                state_n = S_BUSY;
            end
            S_BUSY: begin
                ftx_n = ftx | (tx_done & ~tx_q);
                frx_n = frx | (rx_valid & ~rx_q);
                // completion is checked before timeout so a coincident done wins
                if ((ftx_n | ~m[MODE_TX]) & (frx_n | ~m[MODE_RX])) begin
                    fin     = 1'b1;
                    state_n = S_GAP;
                    cnt_n   = '0;
                end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    fin     = 1'b1;
                    err     = 1'b1;
                    state_n = S_GAP;
                    cnt_n   = '0;
                end
            end
            S_GAP: if (cnt == CNT_W'(GAP_CYCLES - 1)) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            m              <= '0;
            gid            <= 1'b0;
            ftx            <= 1'b0;
            frx            <= 1'b0;
            tx_q           <= 1'b0;
            rx_q           <= 1'b0;
            req_ready      <= '0;
            done_valid     <= '0;
            done_err       <= 1'b0;
            busy           <= 1'b0;
            slave_tx_start <= 1'b0;
            slave_rx_start <= 1'b0;
            loopback       <= 1'b0;
            freq_control   <= FREQ_RESET;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            ftx            <= ftx_n;
            frx            <= frx_n;
            tx_q           <= tx_done;
            rx_q           <= rx_valid;
            req_ready      <= accept ? grant : 2'b00;
            done_valid     <= fin ? {gid, ~gid} : 2'b00;
            done_err       <= fin & err;
            busy           <= state_n != S_IDLE;
            slave_tx_start <= (state_n == S_START) & m[MODE_TX];
            slave_rx_start <= (state_n == S_START) & m[MODE_RX];
            if (accept) begin
                gid          <= grant[1];
                m            <= grant[1] ? req_mode[5:3] : req_mode[2:0];
                freq_control <= grant[1] ? req_freq[3:2] : req_freq[1:0];
                loopback     <= grant[1] ? req_mode[3 + MODE_LB] : req_mode[MODE_LB];
            end
        end
    end
endmodule

// File: tb/tb_spi_xfer_sched.sv
// tb_spi_xfer_sched: directed self-checking bench for spi_xfer_sched
module tb_spi_xfer_sched;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] req_valid = '0;
    logic [5:0] req_mode = '0;
    logic [3:0] req_freq = '0;
    logic [1:0] req_ready, done_valid, freq_control;
    logic       done_err, busy, slave_tx_start, slave_rx_start, loopback;
    logic       tx_done = 1'b0;
    logic       rx_valid = 1'b0;
    int checks = 0;
    int failures = 0;

    spi_xfer_sched dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_mode      (req_mode),
        .req_freq      (req_freq),
        .req_ready     (req_ready),
        .done_valid    (done_valid),
        .done_err      (done_err),
        .busy          (busy),
        .slave_tx_start(slave_tx_start),
        .slave_rx_start(slave_rx_start),
        .loopback      (loopback),
        .freq_control  (freq_control),
        .tx_done       (tx_done),
        .rx_valid      (rx_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic sig(input int w);
        case (w)
            0: return req_ready[0];
            1: return req_ready[1];
            2: return done_valid[0];
            3: return done_valid[1];
            default: return slave_tx_start | slave_rx_start;
        endcase
    endfunction

    // n = negedges advanced until the selected signal is seen high
    task automatic wait_for(input string tag, input int w, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sig(w) && n < bound);
        chk({tag, "_seen"}, 32'(sig(w)), 1);
    endtask

    task automatic serve(input logic [2:0] mode, input int who);
        int n;
        wait_for("serve_start", 4, 20, n);
        chk("serve_start_bits", {slave_rx_start, slave_tx_start}, mode[1:0]);
        repeat (10) @(negedge clk);
        tx_done  = mode[0];
        rx_valid = mode[1];
        @(negedge clk);
        tx_done  = 1'b0;
        rx_valid = 1'b0;
        chk("serve_done", done_valid, (who == 1) ? 2'b10 : 2'b01);
        chk("serve_err", done_err, 0);
    endtask

    initial begin
        int n;
        logic flag;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_done", {done_valid, done_err}, 0);
        chk("rst_starts", {slave_tx_start, slave_rx_start}, 0);
        chk("rst_lb", loopback, 0);
        chk("rst_freq", freq_control, 2'b01);

        // single TX transfer from requester 0
        req_mode = {3'b000, 3'b001};
        req_freq = {2'b00, 2'b01};
        req_valid = 2'b01;
        wait_for("t1_ready", 0, 10, n);
        req_valid = 2'b00;
        chk("t1_ready_lat", n, 1);
        chk("t1_ready_val", req_ready, 2'b01);
        chk("t1_busy", busy, 1);
        wait_for("t1_start", 4, 20, n);
        chk("t1_start_lat", n, 5);
        chk("t1_start_bits", {slave_rx_start, slave_tx_start}, 2'b01);
        repeat (39) @(negedge clk);
        chk("t1_no_early_done", done_valid, 0);
        @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        chk("t1_done", done_valid, 2'b01);
        chk("t1_err", done_err, 0);

        // round-robin alternation after a fresh reset
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        req_mode = {3'b010, 3'b010};
        req_valid = 2'b11;
        wait_for("t2_ready_a", 0, 10, n);
        chk("t2_first_grant", req_ready, 2'b01);
        req_valid = 2'b10;
        serve(3'b010, 0);
        req_valid = 2'b11;
        wait_for("t2_ready_b", 1, 40, n);
        chk("t2_gap_lat", n, 21);
        chk("t2_second_grant", req_ready, 2'b10);
        req_valid = 2'b01;
        serve(3'b010, 1);
        req_valid = 2'b11;
        wait_for("t2_ready_c", 0, 40, n);
        chk("t2_third_lat", n, 21);
        chk("t2_third_grant", req_ready, 2'b01);
        req_valid = 2'b10;
        serve(3'b010, 0);
        wait_for("t2_ready_d", 1, 40, n);
        chk("t2_fourth_grant", req_ready, 2'b10);
        req_valid = 2'b00;
        serve(3'b010, 1);
        repeat (25) @(negedge clk);

        // loopback full-duplex, freq 11
        req_mode = {3'b000, 3'b111};
        req_freq = {2'b00, 2'b11};
        req_valid = 2'b01;
        wait_for("t3_ready", 0, 10, n);
        req_valid = 2'b00;
        chk("t3_setup_cfg", {loopback, freq_control}, 3'b111);
        wait_for("t3_start", 4, 20, n);
        chk("t3_start_lat", n, 5);
        chk("t3_start_bits", {slave_rx_start, slave_tx_start}, 2'b11);
        flag = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (done_valid != 0 || loopback != 1'b1 || freq_control != 2'b11) flag = 1'b0;
            rx_valid = (k == 30);
            tx_done  = (k == 50);
        end
        chk("t3_stable_busy", flag, 1);
        @(negedge clk);
        tx_done = 1'b0;
        chk("t3_done", {done_valid, done_err}, 3'b010);
        repeat (10) @(negedge clk);
        chk("t3_gap_cfg", {busy, loopback, freq_control}, 4'b1111);
        repeat (15) @(negedge clk);

        // timeout on requester 1
        req_mode = {3'b001, 3'b000};
        req_freq = {2'b10, 2'b00};
        req_valid = 2'b10;
        wait_for("t4_ready", 1, 10, n);
        req_valid = 2'b00;
        chk("t4_cfg", {loopback, freq_control}, 3'b010);
        wait_for("t4_start", 4, 20, n);
        wait_for("t4_done", 3, 5000, n);
        chk("t4_timeout_lat", n, 4096);
        chk("t4_err", done_err, 1);
        repeat (19) @(negedge clk);
        chk("t4_gap_busy", busy, 1);
        @(negedge clk);
        chk("t4_idle", busy, 0);

        // invalid modes: no engine start
        req_mode = {3'b000, 3'b000};
        req_valid = 2'b01;
        wait_for("t5_ready_a", 0, 10, n);
        req_valid = 2'b00;
        chk("t5_ready_a_lat", n, 1);
        @(negedge clk);
        chk("t5_done_a", {done_valid, done_err}, 3'b011);
        flag = 1'b0;
        repeat (25) begin
            @(negedge clk);
            flag |= slave_tx_start | slave_rx_start;
        end
        chk("t5_nostart_a", flag, 0);
        req_mode = {3'b101, 3'b000};
        req_valid = 2'b10;
        wait_for("t5_ready_b", 1, 10, n);
        req_valid = 2'b00;
        @(negedge clk);
        chk("t5_done_b", {done_valid, done_err}, 3'b101);
        flag = 1'b0;
        repeat (25) begin
            @(negedge clk);
            flag |= slave_tx_start | slave_rx_start;
        end
        chk("t5_nostart_b", flag, 0);

        // reset pulse during BUSY
        req_mode = {3'b000, 3'b001};
        req_freq = {2'b00, 2'b00};
        req_valid = 2'b01;
        wait_for("t6_ready", 0, 10, n);
        req_valid = 2'b00;
        wait_for("t6_start", 4, 20, n);
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("t6_busy", busy, 0);
        chk("t6_ready_done", {req_ready, done_valid, done_err}, 0);
        chk("t6_starts", {slave_tx_start, slave_rx_start}, 0);
        chk("t6_cfg", {loopback, freq_control}, 3'b001);
        tx_done = 1'b1;
        flag = 1'b0;
        repeat (30) begin
            @(negedge clk);
            tx_done = 1'b0;
            flag |= |done_valid;
        end
        chk("t6_no_done", flag, 0);
        req_mode = {3'b010, 3'b000};
        req_freq = {2'b11, 2'b00};
        req_valid = 2'b10;
        wait_for("t6_ready_new", 1, 10, n);
        req_valid = 2'b00;
        chk("t6_ready_new_lat", n, 1);
        chk("t6_new_freq", freq_control, 2'b11);
        serve(3'b010, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/spi_xfer_sched.md
# spi_xfer_sched

Transaction scheduler sitting in front of the SPI master/slave clock-control engine. Accepts transfer requests from two requesters (UART bridge = 0, local command logic = 1), arbitrates round-robin, programs `freq_control`/`loopback`, issues the one-cycle `slave_tx_start`/`slave_rx_start` pulses, and waits for `tx_done`/`rx_valid`. Reports completion or timeout to the owning requester, then enforces an idle gap before the next grant.

## Interface
- `SETUP_CYCLES`, 4: cycles `freq_control`/`loopback` are held stable before the start pulse.
- `GAP_CYCLES`, 20: idle cycles after completion before the next grant, covering engine return to IDLE.
- `TIMEOUT_CYCLES`, 4096: cycles from start pulse to forced abort.
- `clk` in 1: system clock.
- `reset` in 1: reset is synchronous and active-low.
- `req_valid` in 2: per-requester request, bit i = requester i.
- `req_mode` in 6: 3 bits per requester, `[3i+2:3i]` = {loopback, rx, tx}.
- `req_freq` in 4: 2 bits per requester, `[2i+1:2i]` = engine `freq_control` code.
- `req_ready` out 2: one-cycle accept pulse to requester i.
- `done_valid` out 2: one-cycle completion pulse to requester i.
- `done_err` out 1: qualifies `done_valid`; 1 = timeout or invalid mode.
- `busy` out 1: high in every state except IDLE.
- `slave_tx_start` out 1: engine TX start pulse.
- `slave_rx_start` out 1: engine RX start pulse.
- `loopback` out 1: engine loopback select.
- `freq_control` out 2: engine clock-divider select.
- `tx_done` in 1: engine TX completion.
- `rx_valid` in 1: engine RX completion.

## Operation
- FSM: IDLE → SETUP → START → BUSY → GAP → IDLE.
- IDLE: if any `req_valid`, grant per round-robin, pulse `req_ready[g]`, latch mode/freq, go SETUP.
  - Both requesting: grant the requester not granted last. After reset, priority goes to requester 0.
- Invalid mode: tx=rx=0, or loopback=1 without both tx and rx.
  - Still accepted. `done_valid[g]`+`done_err` pulse on the cycle after accept.
  - Go to GAP. The engine is never started.
- SETUP: drive latched `freq_control`/`loopback` for `SETUP_CYCLES`, then go START.
- START: one cycle.
  - `slave_tx_start` = latched tx, `slave_rx_start` = latched rx.
  - Timeout counter cleared. Go BUSY.
- BUSY: capture rising edges of `tx_done`/`rx_valid` into sticky flags, cleared in START.
  - When every requested flag is set: `done_valid[g]` pulse, `done_err`=0, go GAP.
  - If the counter reaches `TIMEOUT_CYCLES` first: `done_valid[g]`+`done_err`=1, go GAP.
  - Done and timeout on the same cycle: done wins.
- GAP: count `GAP_CYCLES`, then go IDLE.
- `freq_control`/`loopback` hold their latched values from SETUP through GAP and change only on the next accept.
- Requests arriving in non-IDLE states wait. Requesters hold `req_valid`/mode/freq until `req_ready`.
- Counters sized `$clog2(max param + 1)`, saturating, no wrap.

## Timing
- Reset values: `req_ready`, `done_valid`, `done_err`, `busy`, both start pulses, `loopback` = 0; `freq_control` = 2'b01; state IDLE; round-robin pointer favours requester 0.
- Reset (`reset`=0) mid-transfer: next edge returns to IDLE with all outputs at reset values; no `done_valid` for the aborted transfer.
- Accept cycle → start pulse: `SETUP_CYCLES`+1 cycles. Completion edge → `done_valid`: 1 cycle (registered). `done_valid` → next possible `req_ready`: `GAP_CYCLES`+1.
- All outputs registered.

## Structure
- `spi_sched_pkg`:
  - state enum
  - mode bit indices (`MODE_TX`, `MODE_RX`, `MODE_LB`)
  - `FREQ_RESET` = 2'b01
- One sub-module: `rr_arb2` (2-way round-robin, request in, one-hot grant plus pointer update on accept).

## Test plan
- Requester 0 only, mode 3'b001, freq 2'b01, engine `tx_done` 40 cycles after start → `req_ready[0]` pulse; start pulse exactly 5 cycles after accept; `done_valid[0]`=1, `done_err`=0, one cycle after `tx_done`.
- Both request simultaneously after reset, mode 3'b010 → requester 0 granted first, requester 1 granted `GAP_CYCLES`+1 after `done_valid[0]`; next simultaneous pair → order alternates.
- Mode 3'b111, freq 2'b11: `rx_valid` at +30, `tx_done` at +50 → `loopback`=1 and `freq_control`=2'b11 stable SETUP through GAP; `done_valid` only after `tx_done`.
- Mode 3'b001, engine never asserts `tx_done` → `done_err`=1 exactly `TIMEOUT_CYCLES` after start; FSM passes through GAP to IDLE.
- Mode 3'b000 or 3'b101 → `req_ready` then `done_valid`+`done_err` next cycle; no start pulse.
- `reset` low for 1 cycle during BUSY → all outputs at reset values next cycle; no `done_valid` for the aborted transfer; a new request is accepted normally.
